// File: rtl/fft_tile_cmac.sv
// fft_tile_cmac
//   Complex multiply-accumulate over 4x4 frequency-domain image tiles.
//   Each channel arrives as two 512-bit beats (real plane, then imag plane).
//   Every word is multiplied by the stored kernel spectrum and summed over
//   num_channels channels. The summed tile leaves as a real cacheline and
//   then an imag cacheline.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   input_valid           cacheline_in holds a beat this cycle
//   cacheline_in[511:0]   16 signed Q(32-FRAC_BITS).FRAC_BITS words, w = 4*row+col
//   input_ready           high while collecting; beats offered while it is low are dropped
//   kernel_we             write kernel_cacheline into the plane chosen by kernel_sel
//   kernel_sel            0 = real plane, 1 = imag plane
//   kernel_cacheline      kernel plane, same word layout as cacheline_in
//   num_channels          channels per output tile (0 means 1), sampled on channel 0 real beat
//   output_valid          registered, cacheline_out holds a plane this cycle
//   cacheline_out         registered accumulated plane (real first, then imag)
//   output_fifo_full      downstream back-pressure
//   busy                  high while a tile is in progress
module fft_tile_cmac #(
   parameter int FRAC_BITS = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         input_valid,
   input  logic [511:0] cacheline_in,
   output logic         input_ready,
   input  logic         kernel_we,
   input  logic         kernel_sel,
   input  logic [511:0] kernel_cacheline,
   input  logic [15:0]  num_channels,
   output logic         output_valid,
   output logic [511:0] cacheline_out,
   input  logic         output_fifo_full,
   output logic         busy
);

   typedef enum logic [2:0] {
      COLLECT_RE,
      COLLECT_IM,
      MAC,
      EMIT_RE,
      EMIT_IM
   } state_t;

   state_t       r_state;
   logic [15:0]  r_chan_cnt;
   logic [15:0]  r_num_ch;
   logic [511:0] r_a_re;
   logic [511:0] r_a_im;
   logic [511:0] r_k_re;
   logic [511:0] r_k_im;
   logic [511:0] r_acc_re;
   logic [511:0] r_acc_im;
   logic [511:0] w_acc_re_nxt;
   logic [511:0] w_acc_im_nxt;

   // Real part of (ar + j*ai) * (kr + j*ki); full 65-bit difference before
   // the fixed-point shift, then wrap to 32 bits.
   function automatic logic signed [31:0] cmul_re(
      input logic signed [31:0] ar,
      input logic signed [31:0] ai,
      input logic signed [31:0] kr,
      input logic signed [31:0] ki
   );
      logic signed [63:0] p0;
      logic signed [63:0] p1;
      p0 = 64'(ar) * 64'(kr);
      p1 = 64'(ai) * 64'(ki);
      return 32'((65'(p0) - 65'(p1)) >>> FRAC_BITS);
   endfunction

   // Imag part of the same product.
   function automatic logic signed [31:0] cmul_im(
      input logic signed [31:0] ar,
      input logic signed [31:0] ai,
      input logic signed [31:0] kr,
      input logic signed [31:0] ki
   );
      logic signed [63:0] p0;
      logic signed [63:0] p1;
      p0 = 64'(ar) * 64'(ki);
      p1 = 64'(ai) * 64'(kr);
      return 32'((65'(p0) + 65'(p1)) >>> FRAC_BITS);
   endfunction

   // First channel overwrites the accumulator so no clear cycle is needed.
   always_comb begin
      w_acc_re_nxt = '0;
      w_acc_im_nxt = '0;
      for (int w = 0; w < 16; w++) begin
         logic signed [31:0] pr;
         logic signed [31:0] pi;
         pr = cmul_re(r_a_re[32*w +: 32], r_a_im[32*w +: 32],
                      r_k_re[32*w +: 32], r_k_im[32*w +: 32]);
         pi = cmul_im(r_a_re[32*w +: 32], r_a_im[32*w +: 32],
                      r_k_re[32*w +: 32], r_k_im[32*w +: 32]);
         if (r_chan_cnt == 16'd0) begin
            w_acc_re_nxt[32*w +: 32] = pr;
            w_acc_im_nxt[32*w +: 32] = pi;
         end else begin
            w_acc_re_nxt[32*w +: 32] = r_acc_re[32*w +: 32] + pr;
            w_acc_im_nxt[32*w +: 32] = r_acc_im[32*w +: 32] + pi;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= COLLECT_RE;
         r_chan_cnt    <= '0;
         r_num_ch      <= 16'd1;
         r_a_re        <= '0;
         r_a_im        <= '0;
         r_k_re        <= '0;
         r_k_im        <= '0;
         r_acc_re      <= '0;
         r_acc_im      <= '0;
         output_valid  <= 1'b0;
         cacheline_out <= '0;
      end else begin
         output_valid <= 1'b0;

         // Kernel writes are independent of the tile FSM; a write landing in
         // the MAC cycle is only seen by the following MAC.
         if (kernel_we) begin
            if (kernel_sel) r_k_im <= kernel_cacheline;
            else            r_k_re <= kernel_cacheline;
         end

         case (r_state)
            COLLECT_RE: begin
               if (input_valid) begin
                  r_a_re  <= cacheline_in;
                  r_state <= COLLECT_IM;
                  if (r_chan_cnt == 16'd0)
                     r_num_ch <= (num_channels == 16'd0) ? 16'd1 : num_channels;
               end
            end
            COLLECT_IM: begin
               if (input_valid) begin
                  r_a_im  <= cacheline_in;
                  r_state <= MAC;
               end
            end
            MAC: begin
               r_acc_re <= w_acc_re_nxt;
               r_acc_im <= w_acc_im_nxt;
               if (r_chan_cnt == r_num_ch - 16'd1) begin
                  r_state <= EMIT_RE;
               end else begin
                  r_chan_cnt <= r_chan_cnt + 16'd1;
                  r_state    <= COLLECT_RE;
               end
            end
            EMIT_RE: begin
               if (!output_fifo_full) begin
                  output_valid  <= 1'b1;
                  cacheline_out <= r_acc_re;
                  r_state       <= EMIT_IM;
               end
            end
            EMIT_IM: begin
               if (!output_fifo_full) begin
                  output_valid  <= 1'b1;
                  cacheline_out <= r_acc_im;
                  r_chan_cnt    <= '0;
                  r_state       <= COLLECT_RE;
               end
            end
            default: r_state <= COLLECT_RE;
         endcase
      end
   end

   assign input_ready = (r_state == COLLECT_RE) || (r_state == COLLECT_IM);
   assign busy        = (r_state != COLLECT_RE) || (r_chan_cnt != 16'd0);

endmodule

// File: tb/tb_fft_tile_cmac.sv
module tb_fft_tile_cmac;

   logic         clk = 1'b0;
   logic         reset;
   logic         input_valid;
   logic [511:0] cacheline_in;
   logic         input_ready;
   logic         kernel_we;
   logic         kernel_sel;
   logic [511:0] kernel_cacheline;
   logic [15:0]  num_channels;
   logic         output_valid;
   logic [511:0] cacheline_out;
   logic         output_fifo_full;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int vld_cnt = 0;

   localparam logic [31:0] ONE = 32'h0001_0000;

   always #5 clk = ~clk;

   fft_tile_cmac #(.FRAC_BITS(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .input_valid      (input_valid),
      .cacheline_in     (cacheline_in),
      .input_ready      (input_ready),
      .kernel_we        (kernel_we),
      .kernel_sel       (kernel_sel),
      .kernel_cacheline (kernel_cacheline),
      .num_channels     (num_channels),
      .output_valid     (output_valid),
      .cacheline_out    (cacheline_out),
      .output_fifo_full (output_fifo_full),
      .busy             (busy)
   );

   always @(posedge clk) if (output_valid) vld_cnt <= vld_cnt + 1;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] fill(input logic [31:0] v);
      return {16{v}};
   endfunction

   function automatic logic [511:0] ramp();
      logic [511:0] r;
      r = '0;
      for (int w = 0; w < 16; w++) r[32*w +: 32] = 32'(w) << 16;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_kernel(input logic [511:0] kre, input logic [511:0] kim);
      kernel_we        = 1'b1;
      kernel_sel       = 1'b0;
      kernel_cacheline = kre;
      step();
      kernel_sel       = 1'b1;
      kernel_cacheline = kim;
      step();
      kernel_we        = 1'b0;
   endtask

   task automatic beat(input logic [511:0] d);
      int n;
      n = 0;
      while (!input_ready && n < 50) begin
         step();
         n++;
      end
      if (!input_ready) check("ready_timeout", 512'(input_ready), 512'(1));
      input_valid  = 1'b1;
      cacheline_in = d;
      step();
      input_valid  = 1'b0;
   endtask

   task automatic tile(input logic [511:0] re, input logic [511:0] im);
      beat(re);
      beat(im);
   endtask

   task automatic get_pair(input string tag, input logic [511:0] exp_re, input logic [511:0] exp_im);
      int n;
      n = 0;
      while (!output_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_vld_re"}, 512'(output_valid), 512'(1));
      check({tag, "_re"}, cacheline_out, exp_re);
      step();
      check({tag, "_vld_im"}, 512'(output_valid), 512'(1));
      check({tag, "_im"}, cacheline_out, exp_im);
      step();
   endtask

   initial begin
      int base;
      reset            = 1'b0;
      input_valid      = 1'b0;
      cacheline_in     = '0;
      kernel_we        = 1'b0;
      kernel_sel       = 1'b0;
      kernel_cacheline = '0;
      num_channels     = 16'd1;
      output_fifo_full = 1'b0;
      step();
      step();
      reset = 1'b1;

      check("rst_vld",   512'(output_valid), 512'(0));
      check("rst_out",   cacheline_out, '0);
      check("rst_ready", 512'(input_ready), 512'(1));
      check("rst_busy",  512'(busy), 512'(0));

      // identity kernel, ramp input
      load_kernel(fill(ONE), '0);
      num_channels = 16'd1;
      tile(ramp(), '0);
      get_pair("t1", ramp(), '0);

      // (1+2j)*(3+4j) = -5+10j
      load_kernel(fill(32'h0003_0000), fill(32'h0004_0000));
      tile(fill(32'h0001_0000), fill(32'h0002_0000));
      get_pair("t2", fill(32'hFFFB_0000), fill(32'h000A_0000));

      // three channels summed into one pair
      load_kernel(fill(ONE), '0);
      num_channels = 16'd3;
      base = vld_cnt;
      tile(fill(ONE), '0);
      check("t3_busy", 512'(busy), 512'(1));
      tile(fill(ONE), '0);
      repeat (4) step();
      check("t3_no_early", 512'(vld_cnt), 512'(base));
      tile(fill(ONE), '0);
      get_pair("t3", fill(32'h0003_0000), '0);
      repeat (2) step();
      check("t3_one_pair", 512'(vld_cnt), 512'(base + 2));
      check("t3_idle", 512'(busy), 512'(0));

      // back-pressure while entering EMIT_RE
      num_channels = 16'd1;
      beat(fill(ONE));
      output_fifo_full = 1'b1;
      beat('0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4_held_vld", 512'(output_valid), 512'(0));
         check("t4_held_rdy", 512'(input_ready), 512'(0));
      end
      output_fifo_full = 1'b0;
      get_pair("t4", fill(ONE), '0);

      // reset in the middle of a multi-channel tile
      num_channels = 16'd3;
      tile(fill(32'h0005_0000), fill(32'h0002_0000));
      repeat (2) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("t5_rst_busy", 512'(busy), 512'(0));
      check("t5_rst_out",  cacheline_out, '0);
      check("t5_rst_rdy",  512'(input_ready), 512'(1));
      load_kernel(fill(ONE), '0);
      num_channels = 16'd1;
      tile(ramp(), '0);
      get_pair("t5", ramp(), '0);

      // N=0 acts as one channel; two channels wrap past the positive limit
      num_channels = 16'd0;
      tile(fill(32'h7FFF_0000), '0);
      get_pair("t6a", fill(32'h7FFF_0000), '0);
      num_channels = 16'd2;
      tile(fill(32'h7FFF_0000), '0);
      tile(fill(ONE), '0);
      get_pair("t6b", fill(32'h8000_0000), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
